// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

   localparam int unsigned FETCH_QUEUE_DEPTH      = 4;
   localparam int unsigned FETCH_QUEUE_PC_WIDTH   = 32;
   localparam int unsigned FETCH_QUEUE_DATA_WIDTH = 32;

   // Field names follow the fetch_to_decode_t stage link so entries map across directly.
   typedef struct packed {
      logic [FETCH_QUEUE_PC_WIDTH-1:0]   pc;
      logic [FETCH_QUEUE_DATA_WIDTH-1:0] instr;
   } fetch_queue_entry_t;

endpackage

// File: rtl/fetch_queue_ptr.sv
// Wrap-bit queue pointer: the MSB toggles each time the index passes DEPTH-1.
module fetch_queue_ptr #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] ptr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= load_value;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Decoupling {pc, instr} queue between fetch and decode, flushed on a taken branch.
// Optional same-cycle empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH      = FETCH_QUEUE_DEPTH,
   parameter int unsigned DATA_WIDTH = FETCH_QUEUE_DATA_WIDTH,
   parameter int unsigned PC_WIDTH   = FETCH_QUEUE_PC_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PC_WIDTH-1:0]      in_pc,
   input  logic [DATA_WIDTH-1:0]    in_instr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_WIDTH-1:0]      out_pc,
   output logic [DATA_WIDTH-1:0]    out_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = PC_WIDTH + DATA_WIDTH;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] head;
   logic          empty;
   logic          full;
   logic          bypass;
   logic          push;
   logic          pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign in_ready = !full;
   assign count    = wr_ptr - rd_ptr;
   assign head     = mem[rd_ptr[AW-1:0]];

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = empty && in_valid && !flush;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed entry taken by decode in the same cycle is never stored.
   assign push = in_valid && in_ready && !flush && !(bypass && out_ready);
   assign pop  = !empty && out_ready && !flush;

   always_comb begin
      out_valid = 1'b0;
      out_pc    = '0;
      out_instr = '0;
      if (!empty) begin
         out_valid = 1'b1;
         out_pc    = head[EW-1:DATA_WIDTH];
         out_instr = head[DATA_WIDTH-1:0];
      end else if (bypass) begin
         out_valid = 1'b1;
         out_pc    = in_pc;
         out_instr = in_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {in_pc, in_instr};
      end
   end

   // Flush snaps the write pointer onto the read pointer, emptying the queue.
   fetch_queue_ptr #(
      .WIDTH (PW)
   ) u_wr_ptr (
      .clk        (clk),
      .rst        (rst),
      .inc        (push),
      .load       (flush),
      .load_value (rd_ptr),
      .ptr        (wr_ptr)
   );

   fetch_queue_ptr #(
      .WIDTH (PW)
   ) u_rd_ptr (
      .clk        (clk),
      .rst        (rst),
      .inc        (pop),
      .load       (1'b0),
      .load_value ({PW{1'b0}}),
      .ptr        (rd_ptr)
   );

`ifndef SYNTHESIS
   a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full));
   a_count_max    : assert property (@(posedge clk) disable iff (rst) count <= PW'(DEPTH));
   a_out_stable   : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !flush) |=> ($stable(out_pc) && $stable(out_instr)));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int unsigned DEPTH = FETCH_QUEUE_DEPTH;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                        clk;
   logic                        rst;
   logic                        flush;
   logic                        in_valid;
   logic                        in_ready;
   logic [31:0]                 in_pc;
   logic [31:0]                 in_instr;
   logic                        out_valid;
   logic                        out_ready;
   logic [31:0]                 out_pc;
   logic [31:0]                 out_instr;
   logic [$clog2(DEPTH):0]      count;

   fetch_queue_entry_t model[$];
   logic [31:0]        obs_pc[$];
   int                 n_checks;
   int                 n_fail;

   fetch_queue dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .count     (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, compare against the model, then advance the model.
   task automatic step(input logic f, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy);
      logic        byp;
      logic        exp_valid;
      logic        exp_ready;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      @(negedge clk);
      flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
      #1;
      byp       = BYPASS && (model.size() == 0) && iv && !f;
      exp_ready = (model.size() < DEPTH);
      exp_valid = (model.size() != 0) || byp;
      exp_pc    = '0;
      exp_instr = '0;
      if (model.size() != 0) begin
         exp_pc    = model[0].pc;
         exp_instr = model[0].instr;
      end else if (byp) begin
         exp_pc    = pc;
         exp_instr = ins;
      end
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'(exp_valid));
      check("out_pc", 64'(out_pc), 64'(exp_pc));
      check("out_instr", 64'(out_instr), 64'(exp_instr));
      check("count", 64'(count), 64'(model.size()));
      if (out_valid && ordy) obs_pc.push_back(out_pc);
      @(posedge clk);
      if (f) begin
         model.delete();
      end else if (!(byp && ordy)) begin
         if (exp_valid && ordy) void'(model.pop_front());
         if (iv && exp_ready) model.push_back('{pc: pc, instr: ins});
      end
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
   endtask

   logic [31:0] w0;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_pc", 64'(out_pc), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Fill to full with decode stalled.
      w0 = $urandom;
      step(1'b0, 1'b1, 32'h0, w0, 1'b0);
      for (int i = 1; i < 4; i++) step(1'b0, 1'b1, 32'(4 * i), $urandom, 1'b0);
      #1;
      check("fill_count", 64'(count), 64'd4);
      check("fill_in_ready", 64'(in_ready), 64'd0);
      check("fill_out_pc", 64'(out_pc), 64'h0);
      check("fill_out_instr", 64'(out_instr), 64'(w0));

      // Full: pop one, the offered push is refused.
      obs_pc.delete();
      step(1'b0, 1'b1, 32'h10, $urandom, 1'b1);
      #1;
      check("full_pop_pc", 64'(obs_pc.size() == 1 ? obs_pc[0] : 32'hdead), 64'h0);
      check("full_pop_count", 64'(count), 64'd3);
      check("full_pop_in_ready", 64'(in_ready), 64'd1);
      drain();

      // Streaming across the pointer wrap.
      obs_pc.delete();
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b1);
      drain();
      check("stream_len", 64'(obs_pc.size()), 64'd10);
      foreach (obs_pc[i]) check("stream_order", 64'(obs_pc[i]), 64'h100 + 64'(4 * i));

      // Flush with a concurrent push.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h1000 + 32'(4 * i), $urandom, 1'b0);
      step(1'b1, 1'b1, 32'h200, $urandom, 1'b0);
      #1;
      check("flush_count", 64'(count), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      step(1'b0, 1'b1, 32'h300, $urandom, 1'b0);
      #1;
      check("flush_next_head", 64'(out_pc), 64'h300);
      drain();

      // Asynchronous reset mid-cycle with entries queued.
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 32'h400 + 32'(4 * i), $urandom, 1'b0);
      #2;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'd0);
      check("async_rst_count", 64'(count), 64'd0);
      model.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b1, 32'h500, $urandom, 1'b0);
      #1;
      check("post_rst_head", 64'(out_pc), 64'h500);
      drain();

`ifdef FETCH_QUEUE_BYPASS_EN
      step(1'b0, 1'b1, 32'h40, $urandom, 1'b1);
      #1;
      check("bypass_count", 64'(count), 64'd0);
`endif

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(15) == 0), 1'($urandom), $urandom, $urandom, 1'($urandom));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
